mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port behavioural memory (1-cycle registered read, byte-strobed write) between two requesters: instruction fetch (port I) and load/store (port D).
- Sits between the core's fetch/LSU logic and a unified memory instance, so one RAM holds both code and data.
- Grants at most one access per cycle, tracks the owner of the in-flight read, and routes the read data back to that owner.

Parameters:
- ADDR_W, 8, word address width (default matches a 256-word memory)
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_WAIT, 4, consecutive cycles port I may be denied before it is force-granted (must be ≥1)

Ports:
- clk  input  1  clock; all state updates on posedge
- cpu_rst  input  1  asynchronous active-high reset
- i_req_valid  input  1  port I request present
- i_req_ready  output  1  port I request accepted this cycle
- i_req_addr  input  ADDR_W  port I word address
- i_rsp_valid  output  1  port I read data valid
- i_rsp_rdata  output  DATA_W  port I read data
- d_req_valid  input  1  port D request present
- d_req_ready  output  1  port D request accepted this cycle
- d_req_we  input  1  port D request is a write
- d_req_addr  input  ADDR_W  port D word address
- d_req_wdata  input  DATA_W  port D write data
- d_req_strobe  input  DATA_W/8  port D byte enables; ignored on reads
- d_rsp_valid  output  1  port D read data valid
- d_rsp_rdata  output  DATA_W  port D read data
- mem_rd_addr  output  ADDR_W  memory read address
- mem_wr_addr  output  ADDR_W  memory write address
- mem_wr_data  output  DATA_W  memory write data
- mem_wr_strobe  output  DATA_W/8  memory byte write enables
- mem_rd_data  input  DATA_W  memory read data, valid 1 cycle after mem_rd_addr

Behaviour:
- Reset (async assert, sync release), all held 0 until release:
  - rsp_valids = 0
  - in-flight flag/owner cleared
  - wait counter = 0
  - last-grant = D
  - mem_rd_addr = 0
- Combinational outputs: mem_wr_strobe = 0 whenever no write is granted.
- Grant (combinational, same cycle):
  - at most one of i_req_ready/d_req_ready is high, and only when the matching valid is high
  - request transfers when valid && ready
- Arbitration:
  - only one valid → that port wins
  - both valid → D wins, unless wait counter == MAX_WAIT, in which case I wins
- Wait counter:
  - increments (saturating at MAX_WAIT) each cycle i_req_valid is high and I is not granted
  - clears on an I grant, or when i_req_valid is low
- Requests do not hold valid-pending state. A requester must keep valid/addr/data stable until ready.
- Read issue: mem_rd_addr = granted address; inflight_vld <= 1 and inflight_owner <= port on the same edge.
- Read latency: exactly 1 cycle from acceptance to rsp_valid.
  - the owner's rsp_valid = inflight_vld registered with mem_rd_data passthrough
  - rsp_rdata = mem_rd_data when owner, else 0
- Back-to-back reads (e.g. D then I in consecutive cycles) are fully pipelined; each response is routed by its own owner tag.
- D write:
  - mem_wr_addr/data/strobe driven in the grant cycle; the memory commits at that edge
  - produces no response
  - inflight_vld <= 0 for that cycle
- Simultaneous write grant and response return: allowed. The response belongs to the previous cycle's read.
- Reset mid-operation: in-flight read discarded; no rsp_valid after reset release until a new read is granted.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports are valid, the port not granted last time wins; last-grant updates on every grant. The wait counter is not instantiated and MAX_WAIT is ignored.
- Undefined: fixed D priority with MAX_WAIT starvation override, as above.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic {PORT_I, PORT_D} mem_port_e
  - localparams for default ADDR_W/DATA_W
- One natural sub-module, mem_arb_grant: pure arbitration logic (valids, wait count / last grant in → one-hot grant out).
- Datapath muxing, owner tracking and counters stay in the top.

Test Plan:
- I-only read, addr 0x10, mem[0x10]=0xDEADBEEF → i_req_ready same cycle; i_rsp_valid=1, rdata=0xDEADBEEF next cycle; d_rsp_valid stays 0.
- D write addr 0x20, wdata 0x11223344, strobe 4'b0011, then D read 0x20 (old 0xAABBCCDD) → read returns 0xAABB3344; no rsp on the write cycle.
- Both valid continuously, MAX_WAIT=4 (fixed priority) → D granted 4 cycles, I granted on the 5th; pattern repeats; I never starves.
- Alternating D read 0x01 / I read 0x02, back-to-back → responses one cycle after each grant, each routed to the correct port with the correct data, no bubbles.
- cpu_rst asserted the cycle after an accepted read → no rsp_valid during or after reset; outputs at reset values immediately (async).
- MEM_ARB_ROUND_ROBIN_EN defined, both valid for 6 cycles → grants alternate I,D,I,D,I,D (first I, since last-grant resets to D).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the I/D memory port arbiter
package mem_arb_pkg;

    typedef enum logic {PORT_I, PORT_D} mem_port_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - one-hot grant selection between fetch (I) and load/store (D)
// MEM_ARB_ROUND_ROBIN_EN selects round robin; otherwise D priority with I starvation override.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int CNT_W    = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic             i_req_valid,
    input  logic             d_req_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic             last_grant,
`else
    input  logic [CNT_W-1:0] wait_cnt,
`endif
    output logic [1:0]       grant
);

    logic favor_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign favor_i = (last_grant == PORT_D);
`else
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    assign favor_i = (wait_cnt == WAIT_LIMIT);
`endif

    always_comb begin
        grant = GRANT_NONE;
        if (i_req_valid && d_req_valid) begin
            grant = favor_i ? GRANT_I : GRANT_D;
        end else if (i_req_valid) begin
            grant = GRANT_I;
        end else if (d_req_valid) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between instruction fetch and load/store
// MEM_ARB_ROUND_ROBIN_EN replaces the starvation counter with round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                cpu_rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_strobe,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic [DATA_W/8-1:0] mem_wr_strobe,
    input  logic [DATA_W-1:0]   mem_rd_data
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [1:0] grant;
    logic       i_fire;
    logic       d_fire;
    logic       d_rd;
    logic       d_wr;
    logic       inflight_vld;
    mem_port_e  inflight_owner;

    // No grants while reset is held, so every memory-side output sits at zero.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_port_e last_grant;

    mem_arb_grant #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_grant (
        .i_req_valid (i_req_valid && !cpu_rst),
        .d_req_valid (d_req_valid && !cpu_rst),
        .last_grant  (last_grant),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            last_grant <= PORT_D;
        end else if (i_fire) begin
            last_grant <= PORT_I;
        end else if (d_fire) begin
            last_grant <= PORT_D;
        end
    end
`else
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    logic [CNT_W-1:0] wait_cnt;

    mem_arb_grant #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_grant (
        .i_req_valid (i_req_valid && !cpu_rst),
        .d_req_valid (d_req_valid && !cpu_rst),
        .wait_cnt    (wait_cnt),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wait_cnt <= '0;
        end else if (!i_req_valid || i_fire) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    assign i_fire      = (grant == GRANT_I);
    assign d_fire      = (grant == GRANT_D);
    assign d_rd        = d_fire && !d_req_we;
    assign d_wr        = d_fire && d_req_we;
    assign i_req_ready = i_fire;
    assign d_req_ready = d_fire;

    always_comb begin
        mem_rd_addr = '0;
        if (i_fire) begin
            mem_rd_addr = i_req_addr;
        end else if (d_rd) begin
            mem_rd_addr = d_req_addr;
        end
    end

    assign mem_wr_addr   = d_wr ? d_req_addr   : '0;
    assign mem_wr_data   = d_wr ? d_req_wdata  : '0;
    assign mem_wr_strobe = d_wr ? d_req_strobe : '0;

    // A write cycle clears the tag; the memory's read data that cycle belongs to nobody.
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            inflight_vld   <= 1'b0;
            inflight_owner <= PORT_I;
        end else begin
            inflight_vld   <= i_fire || d_rd;
            inflight_owner <= i_fire ? PORT_I : PORT_D;
        end
    end

    assign i_rsp_valid = inflight_vld && (inflight_owner == PORT_I);
    assign d_rsp_valid = inflight_vld && (inflight_owner == PORT_D);
    assign i_rsp_rdata = i_rsp_valid ? mem_rd_data : '0;
    assign d_rsp_rdata = d_rsp_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (MEM_ARB_ROUND_ROBIN_EN aware)
module tb_mem_port_arbiter;

    logic        clk;
    logic        cpu_rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [7:0]  i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [7:0]  d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_strobe;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic [7:0]  mem_rd_addr;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strobe;
    logic [31:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .cpu_rst       (cpu_rst),
        .i_req_valid   (i_req_valid),
        .i_req_ready   (i_req_ready),
        .i_req_addr    (i_req_addr),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_rdata   (i_rsp_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_strobe  (d_req_strobe),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_rdata   (d_rsp_rdata),
        .mem_rd_addr   (mem_rd_addr),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_strobe (mem_wr_strobe),
        .mem_rd_data   (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr_strobe[b]) mem[mem_wr_addr][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
        end
        mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
    endtask

    initial begin
        logic [9:0] starve_pat;
        logic [5:0] rr_pat;

        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hAABBCCDD;
        mem[8'h01] = 32'h01010101;
        mem[8'h02] = 32'h02020202;
        mem_rd_data  = 32'h0;
        cpu_rst      = 1'b1;
        i_req_addr   = 8'h0;
        d_req_addr   = 8'h0;
        d_req_wdata  = 32'h0;
        d_req_strobe = 4'h0;
        idle();

        tick();
        tick();
        chk("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
        chk("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        chk("rst_mem_rd_addr", {24'b0, mem_rd_addr}, 32'd0);
        chk("rst_wr_strobe", {28'b0, mem_wr_strobe}, 32'd0);
        @(negedge clk);
        cpu_rst = 1'b0;
        tick();

`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_pat = 6'b010101;
        i_req_valid = 1'b1; i_req_addr = 8'h10;
        d_req_valid = 1'b1; d_req_addr = 8'h01;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_i_ready_%0d", k), {31'b0, i_req_ready}, {31'b0, rr_pat[k]});
            chk($sformatf("rr_d_ready_%0d", k), {31'b0, d_req_ready}, {31'b0, ~rr_pat[k]});
            tick();
        end
        idle();
        tick();
`endif

        // I-only read
        i_req_valid = 1'b1; i_req_addr = 8'h10;
        #1;
        chk("i_only_ready", {31'b0, i_req_ready}, 32'd1);
        chk("i_only_d_ready", {31'b0, d_req_ready}, 32'd0);
        chk("i_only_rd_addr", {24'b0, mem_rd_addr}, 32'h10);
        tick();
        idle();
        chk("i_only_rsp_valid", {31'b0, i_rsp_valid}, 32'd1);
        chk("i_only_rsp_data", i_rsp_rdata, 32'hDEADBEEF);
        chk("i_only_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        chk("i_only_d_rsp_data", d_rsp_rdata, 32'h0);
        tick();
        chk("i_only_rsp_drop", {31'b0, i_rsp_valid}, 32'd0);

        // D byte-strobed write then read back
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 8'h20;
        d_req_wdata = 32'h11223344; d_req_strobe = 4'b0011;
        #1;
        chk("dw_ready", {31'b0, d_req_ready}, 32'd1);
        chk("dw_strobe", {28'b0, mem_wr_strobe}, 32'h3);
        chk("dw_addr", {24'b0, mem_wr_addr}, 32'h20);
        chk("dw_data", mem_wr_data, 32'h11223344);
        tick();
        chk("dw_no_d_rsp", {31'b0, d_rsp_valid}, 32'd0);
        chk("dw_no_i_rsp", {31'b0, i_rsp_valid}, 32'd0);
        d_req_we = 1'b0; d_req_strobe = 4'b1111;
        #1;
        chk("dr_ready", {31'b0, d_req_ready}, 32'd1);
        chk("dr_no_strobe", {28'b0, mem_wr_strobe}, 32'h0);
        tick();
        idle();
        chk("dr_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        chk("dr_rsp_data", d_rsp_rdata, 32'hAABB3344);
        chk("dr_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
        tick();

`ifndef MEM_ARB_ROUND_ROBIN_EN
        // Both valid: D wins four cycles, then I is force-granted
        starve_pat = 10'b1000010000;
        i_req_valid = 1'b1; i_req_addr = 8'h10;
        d_req_valid = 1'b1; d_req_addr = 8'h01;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("stv_i_ready_%0d", k), {31'b0, i_req_ready}, {31'b0, starve_pat[k]});
            chk($sformatf("stv_d_ready_%0d", k), {31'b0, d_req_ready}, {31'b0, ~starve_pat[k]});
            tick();
            chk($sformatf("stv_i_rsp_%0d", k), i_rsp_rdata, starve_pat[k] ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("stv_d_rsp_%0d", k), d_rsp_rdata, starve_pat[k] ? 32'h0 : 32'h01010101);
        end
        idle();
        tick();
`endif

        // Alternating D 0x01 / I 0x02 back-to-back
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                i_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = 8'h01;
            end else begin
                d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 8'h02;
            end
            #1;
            chk($sformatf("alt_rd_addr_%0d", k), {24'b0, mem_rd_addr}, (k % 2 == 0) ? 32'h01 : 32'h02);
            tick();
            chk($sformatf("alt_i_valid_%0d", k), {31'b0, i_rsp_valid}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("alt_d_valid_%0d", k), {31'b0, d_rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt_i_data_%0d", k), i_rsp_rdata, (k % 2 == 0) ? 32'h0 : 32'h02020202);
            chk($sformatf("alt_d_data_%0d", k), d_rsp_rdata, (k % 2 == 0) ? 32'h01010101 : 32'h0);
        end
        idle();
        tick();

        // Reset asserted the cycle after an accepted read
        i_req_valid = 1'b1; i_req_addr = 8'h10;
        #1;
        chk("mrst_accept", {31'b0, i_req_ready}, 32'd1);
        tick();
        cpu_rst = 1'b1;
        #1;
        chk("mrst_i_rsp_async", {31'b0, i_rsp_valid}, 32'd0);
        chk("mrst_i_data_async", i_rsp_rdata, 32'h0);
        chk("mrst_no_grant", {31'b0, i_req_ready}, 32'd0);
        chk("mrst_rd_addr", {24'b0, mem_rd_addr}, 32'h0);
        idle();
        tick();
        chk("mrst_held_rsp", {31'b0, i_rsp_valid | d_rsp_valid}, 32'd0);
        @(negedge clk);
        cpu_rst = 1'b0;
        tick();
        chk("mrst_after_i", {31'b0, i_rsp_valid}, 32'd0);
        chk("mrst_after_d", {31'b0, d_rsp_valid}, 32'd0);
        tick();
        chk("mrst_after2", {31'b0, i_rsp_valid | d_rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
